keypad_scan: RTL and testbench



---
 rtl/keypad_scan.sv | 158 +++++++++++++++
 tb/tb_keypad_scan.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one active-low column per slot, samples the rows
// at slot end, and debounces whole-matrix scans into single key events plus a hold level.
module keypad_scan #(
   parameter int CLK_DIV   = 100000,
   parameter int DEB_SCANS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int DEB_W = ($clog2(DEB_SCANS + 1) > 4) ? $clog2(DEB_SCANS + 1) : 4;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_SCANS);

   typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       col;
   logic [15:0]      snapshot;
   logic [15:0]      scan_bits;
   logic             slot_end;
   logic             scan_end;
   logic [4:0]       hit_count;
   logic [3:0]       hit_idx;
   logic             is_none;
   logic             is_single;

   state_t           state, state_nxt;
   logic [DEB_W-1:0] deb_cnt, deb_nxt;
   logic [3:0]       cand, cand_nxt;
   logic [3:0]       code_nxt;
   logic             valid_nxt;
   logic             down_nxt;

   assign slot_end = (div_cnt == DIV_LAST);
   assign scan_end = slot_end && (col == 2'd3);

   // Snapshot plus this slot's rows, so the final column is part of the scan result.
   always_comb begin
      scan_bits = snapshot;
      for (int r = 0; r < 4; r++) begin
         if (!row_n[r[1:0]]) scan_bits[{r[1:0], col}] = 1'b1;
      end
   end

   always_comb begin
      hit_count = 5'd0;
      hit_idx   = 4'd0;
      for (int k = 0; k < 16; k++) begin
         if (scan_bits[k[3:0]]) begin
            hit_count = hit_count + 5'd1;
            hit_idx   = k[3:0];
         end
      end
   end

   assign is_none   = (hit_count == 5'd0);
   assign is_single = (hit_count == 5'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt  <= '0;
         col      <= 2'd0;
         col_n    <= 4'b1110;
         snapshot <= '0;
      end else if (slot_end) begin
         div_cnt  <= '0;
         col      <= col + 2'd1;
         col_n    <= ~(4'b0001 << (col + 2'd1));
         snapshot <= (col == 2'd3) ? 16'd0 : scan_bits;
      end else begin
         div_cnt  <= div_cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         deb_cnt   <= '0;
         cand      <= 4'd0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_down  <= 1'b0;
      end else begin
         state     <= state_nxt;
         deb_cnt   <= deb_nxt;
         cand      <= cand_nxt;
         key_code  <= code_nxt;
         key_valid <= valid_nxt;
         key_down  <= down_nxt;
      end
   end

   // Debounce FSM only advances on scan boundaries; held state ignores rollover and ghosts.
   always_comb begin
      state_nxt = state;
      deb_nxt   = deb_cnt;
      cand_nxt  = cand;
      code_nxt  = key_code;
      valid_nxt = 1'b0;
      down_nxt  = key_down;
      if (scan_end) begin
         case (state)
            IDLE: begin
               if (is_single) begin
                  cand_nxt  = hit_idx;
                  deb_nxt   = DEB_W'(1);
                  state_nxt = CONFIRM;
               end
            end
            CONFIRM: begin
               if (is_single && hit_idx == cand) begin
                  if (deb_cnt + DEB_W'(1) == DEB_LAST) begin
                     code_nxt  = cand;
                     valid_nxt = 1'b1;
                     down_nxt  = 1'b1;
                     deb_nxt   = '0;
                     state_nxt = HELD;
                  end else begin
                     deb_nxt = deb_cnt + DEB_W'(1);
                  end
               end else begin
                  deb_nxt   = '0;
                  state_nxt = IDLE;
               end
            end
            HELD: begin
               if (is_none) begin
                  deb_nxt   = DEB_W'(1);
                  state_nxt = RELEASE;
               end
            end
            RELEASE: begin
               if (is_none) begin
                  if (deb_cnt + DEB_W'(1) == DEB_LAST) begin
                     down_nxt  = 1'b0;
                     deb_nxt   = '0;
                     state_nxt = IDLE;
                  end else begin
                     deb_nxt = deb_cnt + DEB_W'(1);
                  end
               end else begin
                  deb_nxt   = '0;
                  state_nxt = HELD;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural keypad matrix and an event scoreboard.
module tb_keypad_scan;

   logic        clk;
   logic        rst;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_down;
   logic [15:0] pressed;

   logic [3:0]  exp_q[$];
   int          n_vec;
   int          n_err;
   int          n_pulses;

   keypad_scan #(.CLK_DIV(4), .DEB_SCANS(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .row_n     (row_n),
      .col_n     (col_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_down  (key_down)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Row r reads low when any pressed key in that row sits on the driven column.
   assign row_n[0] = ~|(pressed[3:0]   & ~col_n);
   assign row_n[1] = ~|(pressed[7:4]   & ~col_n);
   assign row_n[2] = ~|(pressed[11:8]  & ~col_n);
   assign row_n[3] = ~|(pressed[15:12] & ~col_n);

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         n_pulses++;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got key_code %0d, expected no event at %0t",
                     key_code, $time);
         end else begin
            logic [3:0] exp_code;
            exp_code = exp_q.pop_front();
            check("event_code", key_code, exp_code);
            check("event_down", key_down, 1'b1);
         end
      end
   end

   initial begin
      int         n0;
      int         lat;
      logic       found;
      logic [3:0] exp_col;
      n_vec    = 0;
      n_err    = 0;
      n_pulses = 0;
      rst      = 1'b1;
      pressed  = 16'd0;

      // Scenario 1: reset, idle column walk
      tick(3);
      rst = 1'b0;
      for (int i = 0; i < 36; i++) begin
         exp_col = 4'b0001 << ((i / 4) % 4);
         exp_col = ~exp_col;
         check("s1_col_n", col_n, exp_col);
         check("s1_valid", key_valid, 1'b0);
         check("s1_down", key_down, 1'b0);
         check("s1_code", key_code, 4'd0);
         tick(1);
      end

      // Scenario 2: clean press of key 6
      n0 = n_pulses;
      exp_q.push_back(4'd6);
      pressed = 16'h0040;
      lat = 0;
      for (int i = 1; i <= 65; i++) begin
         tick(1);
         if (lat == 0 && key_valid === 1'b1) lat = i;
      end
      check("s2_valid_seen", lat != 0, 1'b1);
      check("s2_latency_min", lat >= 33, 1'b1);
      tick(35);
      check("s2_down", key_down, 1'b1);
      check("s2_code", key_code, 4'd6);
      check("s2_pulses", n_pulses - n0, 1);

      // Scenario 4: one-scan release glitch, then real release
      n0 = n_pulses;
      pressed = 16'd0;
      for (int i = 0; i < 16; i++) begin
         tick(1);
         check("s4_glitch_down", key_down, 1'b1);
      end
      pressed = 16'h0040;
      for (int i = 0; i < 16; i++) begin
         tick(1);
         check("s4_repress_down", key_down, 1'b1);
      end
      pressed = 16'd0;
      for (int i = 0; i < 32; i++) begin
         tick(1);
         check("s4_release_hold", key_down, 1'b1);
      end
      found = 1'b0;
      for (int i = 0; i < 33 && !found; i++) begin
         tick(1);
         if (key_down === 1'b0) found = 1'b1;
      end
      check("s4_down_fell", found, 1'b1);
      check("s4_pulses", n_pulses - n0, 0);
      check("s4_code", key_code, 4'd6);

      // Scenario 3: short press too brief to confirm
      n0 = n_pulses;
      pressed = 16'h0040;
      for (int i = 0; i < 88; i++) begin
         if (i == 24) pressed = 16'd0;
         tick(1);
         check("s3_down", key_down, 1'b0);
      end
      check("s3_pulses", n_pulses - n0, 0);
      check("s3_code", key_code, 4'd6);

      // Scenario 5a: two keys together are ambiguous
      n0 = n_pulses;
      pressed = 16'h0021;
      for (int i = 0; i < 120; i++) begin
         if (i == 100) pressed = 16'd0;
         tick(1);
         check("s5a_down", key_down, 1'b0);
      end
      check("s5a_pulses", n_pulses - n0, 0);

      // Scenario 5b: rollover while key 6 is held
      n0 = n_pulses;
      exp_q.push_back(4'd6);
      pressed = 16'h0040;
      found = 1'b0;
      for (int i = 0; i < 65 && !found; i++) begin
         tick(1);
         if (key_down === 1'b1) found = 1'b1;
      end
      check("s5b_down_rise", found, 1'b1);
      pressed = 16'h0240;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         check("s5b_code", key_code, 4'd6);
         check("s5b_down", key_down, 1'b1);
      end
      check("s5b_pulses", n_pulses - n0, 1);
      pressed = 16'd0;
      found = 1'b0;
      for (int i = 0; i < 70 && !found; i++) begin
         tick(1);
         if (key_down === 1'b0) found = 1'b1;
      end
      check("s5b_down_fell", found, 1'b1);

      // Scenario 6: reset during confirmation of key 15
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick(1);
         if (col_n === 4'b0111) found = 1'b1;
      end
      check("s6_sync_col3", found, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick(1);
         if (col_n === 4'b1110) found = 1'b1;
      end
      check("s6_sync_col0", found, 1'b1);
      pressed = 16'h8000;
      tick(33);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("s6_rst_col_n", col_n, 4'b1110);
      check("s6_rst_down", key_down, 1'b0);
      check("s6_rst_valid", key_valid, 1'b0);
      check("s6_rst_code", key_code, 4'd0);
      exp_q.push_back(4'd15);
      for (int i = 1; i <= 48; i++) begin
         tick(1);
         if (i < 48) check("s6_no_early_valid", key_valid, 1'b0);
         else        check("s6_valid", key_valid, 1'b1);
      end
      check("s6_code", key_code, 4'd15);
      pressed = 16'd0;
      tick(70);

      check("events_outstanding", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
